// File: rtl/regbank_pkg.sv
// regbank_pkg: register indices, RegDst encodings and reset constants shared by the register bank.
package regbank_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_S8 = 5'd30;
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [2:0] RD_RT = 3'b000;
  localparam logic [2:0] RD_RD = 3'b001;
  localparam logic [2:0] RD_RA = 3'b010;
  localparam logic [2:0] RD_SP = 3'b011;
  localparam logic [2:0] RD_S8 = 3'b100;
  localparam logic [31:0] SP_RESET_VAL = 32'd227;
endpackage

// File: rtl/regbank_read_port.sv
// regbank_read_port: combinational read with $zero forcing; write-through forwarding when REGBANK_BYPASS_EN is defined.
module regbank_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] i_regs,
  input  logic [ADDR_W-1:0]                i_idx,
`ifdef REGBANK_BYPASS_EN
  input  logic                             i_we,
  input  logic                             i_rst,
  input  logic [ADDR_W-1:0]                i_widx,
  input  logic [DATA_W-1:0]                i_wdata,
`endif
  output logic [DATA_W-1:0]                o_data
);
`ifdef REGBANK_BYPASS_EN
  logic w_hit;
  assign w_hit = i_we && !i_rst && i_widx != '0 && i_widx == i_idx;
  assign o_data = (i_idx == '0) ? '0 : w_hit ? i_wdata : i_regs[i_idx];
`else
  assign o_data = (i_idx == '0) ? '0 : i_regs[i_idx];
`endif
endmodule

// File: rtl/register_bank.sv
// register_bank: 32x32 MIPS GPR file, $zero hardwired, $sp reset to stack top; REGBANK_BYPASS_EN enables write-through reads.
module register_bank
  import regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SP_IDX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_VAL[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);
  logic [2**ADDR_W-1:0][DATA_W-1:0] r_regs;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
      r_regs[SP_IDX] <= SP_RESET;
    end else if (reg_write && write_reg != '0) begin
      r_regs[write_reg] <= write_data;
    end
  end
  regbank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
    .i_regs(r_regs),
    .i_idx(read_reg1),
`ifdef REGBANK_BYPASS_EN
    .i_we(reg_write),
    .i_rst(reset),
    .i_widx(write_reg),
    .i_wdata(write_data),
`endif
    .o_data(read_data1)
  );
  regbank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
    .i_regs(r_regs),
    .i_idx(read_reg2),
`ifdef REGBANK_BYPASS_EN
    .i_we(reg_write),
    .i_rst(reset),
    .i_widx(write_reg),
    .i_wdata(write_data),
`endif
    .o_data(read_data2)
  );
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed self-checking bench for register_bank; expectations follow REGBANK_BYPASS_EN.
module tb_register_bank;
  logic clk = 0, reset = 0, reg_write = 0;
  logic [4:0] read_reg1 = 0, read_reg2 = 0, write_reg = 0;
  logic [31:0] write_data = 0, read_data1, read_data2;
  int n_checks = 0, n_fail = 0;

  register_bank dut (
    .clk(clk), .reset(reset), .reg_write(reg_write),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    reg_write = 1; write_reg = idx; write_data = d;
    tick();
    reg_write = 0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1; reg_write = 1; write_reg = 5'd7; write_data = 32'hAAAA_AAAA;
    tick();
    reset = 0; reg_write = 0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp;
      exp = (i == 29) ? 32'd227 : 32'd0;
      read_reg1 = i[4:0]; read_reg2 = 5'(31 - i);
      #1;
      n_checks++;
      if (read_data1 !== exp) begin
        $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", i, read_data1, exp);
        n_fail++;
      end
      exp = (31 - i == 29) ? 32'd227 : 32'd0;
      n_checks++;
      if (read_data2 !== exp) begin
        $display("FAIL reset_rd2 idx=%0d got=%h exp=%h", 31 - i, read_data2, exp);
        n_fail++;
      end
    end
  endtask

  task automatic test_write_read;
    wr(5'd8, 32'hDEAD_BEEF);
    read_reg1 = 5'd8; read_reg2 = 5'd8;
    #1;
    n_checks++;
    if (read_data1 !== 32'hDEAD_BEEF) begin
      $display("FAIL wr_rd1 got=%h exp=%h", read_data1, 32'hDEAD_BEEF);
      n_fail++;
    end
    n_checks++;
    if (read_data2 !== 32'hDEAD_BEEF) begin
      $display("FAIL wr_rd2 got=%h exp=%h", read_data2, 32'hDEAD_BEEF);
      n_fail++;
    end
    reg_write = 0; write_reg = 5'd8; write_data = 32'h0BAD_0BAD;
    tick();
    n_checks++;
    if (read_data1 !== 32'hDEAD_BEEF) begin
      $display("FAIL wr_disabled got=%h exp=%h", read_data1, 32'hDEAD_BEEF);
      n_fail++;
    end
  endtask

  task automatic test_zero;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    reg_write = 1; write_reg = 5'd0; write_data = 32'h1234_5678;
    #1;
    n_checks++;
    if (read_data1 !== 32'd0) begin
      $display("FAIL zero_same_cycle got=%h exp=%h", read_data1, 32'd0);
      n_fail++;
    end
    tick();
    reg_write = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
        $display("FAIL zero_after got=%h/%h exp=%h", read_data1, read_data2, 32'd0);
        n_fail++;
      end
    end
  endtask

  task automatic test_hazard;
    logic [31:0] exp;
    wr(5'd5, 32'h11);
    read_reg1 = 5'd5; read_reg2 = 5'd5;
    reg_write = 1; write_reg = 5'd5; write_data = 32'h22;
    #1;
`ifdef REGBANK_BYPASS_EN
    exp = 32'h22;
`else
    exp = 32'h11;
`endif
    n_checks++;
    if (read_data1 !== exp || read_data2 !== exp) begin
      $display("FAIL hazard_same got=%h/%h exp=%h", read_data1, read_data2, exp);
      n_fail++;
    end
    tick();
    reg_write = 0;
    #1;
    n_checks++;
    if (read_data1 !== 32'h22) begin
      $display("FAIL hazard_after got=%h exp=%h", read_data1, 32'h22);
      n_fail++;
    end
  endtask

  task automatic test_regdst;
    wr(5'd31, 32'hA0);
    wr(5'd29, 32'hB0);
    wr(5'd30, 32'hC0);
    read_reg1 = 5'd31; read_reg2 = 5'd29;
    #1;
    n_checks++;
    if (read_data1 !== 32'hA0) begin
      $display("FAIL regdst_ra got=%h exp=%h", read_data1, 32'hA0);
      n_fail++;
    end
    n_checks++;
    if (read_data2 !== 32'hB0) begin
      $display("FAIL regdst_sp got=%h exp=%h", read_data2, 32'hB0);
      n_fail++;
    end
    read_reg1 = 5'd30; read_reg2 = 5'd8;
    #1;
    n_checks++;
    if (read_data1 !== 32'hC0) begin
      $display("FAIL regdst_s8 got=%h exp=%h", read_data1, 32'hC0);
      n_fail++;
    end
    n_checks++;
    if (read_data2 !== 32'hDEAD_BEEF) begin
      $display("FAIL regdst_other8 got=%h exp=%h", read_data2, 32'hDEAD_BEEF);
      n_fail++;
    end
    read_reg1 = 5'd5; read_reg2 = 5'd28;
    #1;
    n_checks++;
    if (read_data1 !== 32'h22 || read_data2 !== 32'd0) begin
      $display("FAIL regdst_other got=%h/%h exp=%h/%h", read_data1, read_data2, 32'h22, 32'd0);
      n_fail++;
    end
  endtask

  task automatic test_reset_collision;
    reset = 1; reg_write = 1; write_reg = 5'd31; write_data = 32'hFFFF;
    read_reg1 = 5'd31; read_reg2 = 5'd29;
    tick();
    reset = 0; reg_write = 0;
    #1;
    n_checks++;
    if (read_data1 !== 32'd0) begin
      $display("FAIL rst_coll_ra got=%h exp=%h", read_data1, 32'd0);
      n_fail++;
    end
    n_checks++;
    if (read_data2 !== 32'd227) begin
      $display("FAIL rst_coll_sp got=%h exp=%h", read_data2, 32'd227);
      n_fail++;
    end
    read_reg1 = 5'd8;
    #1;
    n_checks++;
    if (read_data1 !== 32'd0) begin
      $display("FAIL rst_coll_r8 got=%h exp=%h", read_data1, 32'd0);
      n_fail++;
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_write_read();
    test_zero();
    test_hazard();
    test_regdst();
    test_reset_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
